// File: rtl/counter_pkg.sv
// Shared definitions for the multi-mode counter: the mode encoding used on the
// mode port and by the next-state logic.
package counter_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_UP      = 2'b00;
    localparam mode_t MODE_DOWN    = 2'b01;
    localparam mode_t MODE_JOHNSON = 2'b10;
    localparam mode_t MODE_RING    = 2'b11;

endpackage : counter_pkg

// File: rtl/counter_next_state.sv
// Combinational next-state and terminal-state logic for param_mode_counter:
// load clamping, per-mode step, wrap and illegal-code recovery.
module counter_next_state
    import counter_pkg::*;
#(
    parameter int              WIDTH   = 4,
    parameter longint unsigned MODULUS = 64'd1 << WIDTH
) (
    input  logic [WIDTH-1:0] q_i,
    input  mode_t            mode_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] q_next_o,
    output logic             term_o
);

    localparam logic [WIDTH-1:0] ZERO     = '0;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 64'd1);
    localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] q_inv;
    logic [WIDTH-1:0] up_step;
    logic [WIDTH-1:0] down_step;
    logic [WIDTH-1:0] john_step;
    logic [WIDTH-1:0] ring_step;
    logic [WIDTH-1:0] clamp_d;
    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] load_val;
    logic             john_legal;

    assign q_inv = ~q_i;

    // q > MAX_VAL only happens after a mode switch; it shares the wrap paths.
    assign up_step   = (q_i >= MAX_VAL) ? ZERO : q_i + ONE;
    assign down_step = (q_i == ZERO || q_i > MAX_VAL) ? MAX_VAL : q_i - ONE;
    assign clamp_d   = (d_i > MAX_VAL) ? MAX_VAL : d_i;

    assign john_legal = ((q_i & (q_i + ONE)) == ZERO) ||
                        ((q_inv & (q_inv + ONE)) == ZERO);
    assign john_step  = john_legal ? {q_i[WIDTH-2:0], ~q_i[WIDTH-1]} : ZERO;
    assign ring_step  = $onehot(q_i) ? {q_i[WIDTH-2:0], q_i[WIDTH-1]} : ONE;

    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        step_val = q_i;
        load_val = d_i;
        term_o   = 1'b0;
        case (mode_i)
            MODE_UP: begin
                step_val = up_step;
                load_val = clamp_d;
                term_o   = (q_i == MAX_VAL);
            end
            MODE_DOWN: begin
                step_val = down_step;
                load_val = clamp_d;
                term_o   = (q_i == ZERO);
            end
            MODE_JOHNSON: begin
                step_val = john_step;
                term_o   = (q_i == MSB_ONLY);
            end
            default: begin
                step_val = ring_step;
                term_o   = (q_i == MSB_ONLY);
            end
        endcase
    end

    assign q_next_o = load_i ? load_val : (en_i ? step_val : q_i);

endmodule : counter_next_state

// File: rtl/param_mode_counter.sv
// Parametrised multi-mode counter: q register with asynchronous reset and a
// cascadable combinational terminal-count output.
module param_mode_counter
    import counter_pkg::*;
#(
    parameter int              WIDTH   = 4,
    parameter longint unsigned MODULUS = 64'd1 << WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] q,
    output logic             tc
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             term;

    counter_next_state #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_next (
        .q_i      (q_q),
        .mode_i   (mode),
        .load_i   (load),
        .d_i      (d),
        .en_i     (en),
        .q_next_o (q_d),
        .term_o   (term)
    );

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) q_q <= '0;
        else     q_q <= q_d;
    end

    assign q  = q_q;
    // Kept combinational so it can feed a downstream counter's en in the same cycle.
    assign tc = term & en;

endmodule : param_mode_counter

// File: tb/tb_param_mode_counter.sv
// Scoreboard bench for param_mode_counter: directed vectors push expected q/tc,
// a monitor pops and compares mid-cycle. Covers WIDTH=4/MODULUS=10 and WIDTH=8.
module tb_param_mode_counter;
    import counter_pkg::*;

    typedef struct {
        string      name;
        bit         wide;
        logic [7:0] q;
        logic       tc;
    } exp_t;

    logic       clk;
    logic       rst4, en4, load4;
    logic [3:0] d4;
    logic [1:0] mode4;
    logic [3:0] q4;
    logic       tc4;

    logic       rst8, en8, load8;
    logic [7:0] d8;
    logic [1:0] mode8;
    logic [7:0] q8;
    logic       tc8;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    localparam logic [3:0] UP_SEQ [12] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5,
                                           4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1};
    localparam logic [3:0] DN_SEQ [12] = '{4'd0, 4'd9, 4'd8, 4'd7, 4'd6, 4'd5,
                                           4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd9};
    localparam logic [3:0] JN_SEQ [9]  = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111,
                                           4'b1110, 4'b1100, 4'b1000, 4'b0000};
    localparam logic [3:0] RG_SEQ [6]  = '{4'b0000, 4'b0001, 4'b0010, 4'b0100,
                                           4'b1000, 4'b0001};

    param_mode_counter #(.WIDTH(4), .MODULUS(10)) dut4 (
        .clk  (clk),
        .rst  (rst4),
        .en   (en4),
        .load (load4),
        .d    (d4),
        .mode (mode4),
        .q    (q4),
        .tc   (tc4)
    );

    param_mode_counter #(.WIDTH(8), .MODULUS(256)) dut8 (
        .clk  (clk),
        .rst  (rst8),
        .en   (en8),
        .load (load8),
        .d    (d8),
        .mode (mode8),
        .q    (q8),
        .tc   (tc8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs apply for one cycle; expected q/tc are what the DUT shows during it.
    task automatic vec4(input string name, input logic r, input logic e, input logic l,
                        input logic [3:0] dv, input mode_t m,
                        input logic [3:0] eq, input logic et);
        exp_t x;
        @(posedge clk);
        #1;
        rst4 = r; en4 = e; load4 = l; d4 = dv; mode4 = m;
        x.name = name; x.wide = 1'b0; x.q = {4'h0, eq}; x.tc = et;
        sb.push_back(x);
    endtask

    task automatic vec8(input string name, input logic r, input logic e, input logic l,
                        input logic [7:0] dv, input logic [7:0] eq, input logic et);
        exp_t x;
        @(posedge clk);
        #1;
        rst8 = r; en8 = e; load8 = l; d8 = dv; mode8 = MODE_UP;
        x.name = name; x.wide = 1'b1; x.q = eq; x.tc = et;
        sb.push_back(x);
    endtask

    task automatic check(input string name, input logic [7:0] got_q, input logic got_tc,
                         input logic [7:0] exp_q, input logic exp_tc);
        n_vec++;
        if (got_q !== exp_q || got_tc !== exp_tc) begin
            n_fail++;
            $display("FAIL %s: got q=%0d tc=%b, expected q=%0d tc=%b",
                     name, got_q, got_tc, exp_q, exp_tc);
        end
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                x = sb.pop_front();
                if (x.wide) check(x.name, q8, tc8, x.q, x.tc);
                else        check(x.name, {4'h0, q4}, tc4, x.q, x.tc);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        rst4 = 1'b1; en4 = 1'b0; load4 = 1'b0; d4 = '0; mode4 = MODE_UP;
        rst8 = 1'b1; en8 = 1'b0; load8 = 1'b0; d8 = '0; mode8 = MODE_UP;

        vec4("reset", 1, 0, 0, 4'd0, MODE_UP, 4'd0, 1'b0);

        for (int i = 0; i < 12; i++)
            vec4("up_count", 0, 1, 0, 4'd0, MODE_UP, UP_SEQ[i], UP_SEQ[i] == 4'd9);

        vec4("load_zero", 0, 0, 1, 4'd0, MODE_UP, 4'd2, 1'b0);
        for (int i = 0; i < 12; i++)
            vec4("down_count", 0, 1, 0, 4'd0, MODE_DOWN, DN_SEQ[i], DN_SEQ[i] == 4'd0);
        vec4("down_hold0", 0, 0, 0, 4'd0, MODE_DOWN, 4'd8, 1'b0);
        vec4("down_hold1", 0, 0, 0, 4'd0, MODE_DOWN, 4'd8, 1'b0);
        vec4("down_resume", 0, 1, 0, 4'd0, MODE_DOWN, 4'd8, 1'b0);
        vec4("down_hold2", 0, 0, 0, 4'd0, MODE_DOWN, 4'd7, 1'b0);
        vec4("down_load0", 0, 0, 1, 4'd0, MODE_DOWN, 4'd7, 1'b0);
        vec4("down_tc_gated", 0, 0, 0, 4'd0, MODE_DOWN, 4'd0, 1'b0);
        vec4("down_tc_en", 0, 1, 0, 4'd0, MODE_DOWN, 4'd0, 1'b1);

        vec4("load_clamp13", 0, 0, 1, 4'd13, MODE_UP, 4'd9, 1'b0);
        vec4("load_over_en", 0, 1, 1, 4'd4, MODE_UP, 4'd9, 1'b1);
        vec4("load_clamp10", 0, 0, 1, 4'd10, MODE_UP, 4'd4, 1'b0);
        vec4("clamp_result", 0, 0, 0, 4'd0, MODE_UP, 4'd9, 1'b0);

        vec4("john_raw_load", 0, 0, 1, 4'd15, MODE_JOHNSON, 4'd9, 1'b0);
        vec4("up_from_over", 0, 1, 0, 4'd0, MODE_UP, 4'd15, 1'b0);
        vec4("john_raw_load2", 0, 0, 1, 4'd15, MODE_JOHNSON, 4'd0, 1'b0);
        vec4("down_from_over", 0, 1, 0, 4'd0, MODE_DOWN, 4'd15, 1'b0);
        vec4("john_load0", 0, 0, 1, 4'd0, MODE_JOHNSON, 4'd9, 1'b0);

        for (int i = 0; i < 9; i++)
            vec4("johnson", 0, 1, 0, 4'd0, MODE_JOHNSON, JN_SEQ[i], JN_SEQ[i] == 4'b1000);
        vec4("john_load_bad", 0, 0, 1, 4'b0101, MODE_JOHNSON, 4'b0001, 1'b0);
        vec4("john_step_bad", 0, 1, 0, 4'd0, MODE_JOHNSON, 4'b0101, 1'b0);
        vec4("john_recover", 0, 0, 0, 4'd0, MODE_JOHNSON, 4'b0000, 1'b0);

        vec4("ring_reset", 1, 0, 0, 4'd0, MODE_RING, 4'd0, 1'b0);
        for (int i = 0; i < 6; i++)
            vec4("ring", 0, 1, 0, 4'd0, MODE_RING, RG_SEQ[i], RG_SEQ[i] == 4'b1000);
        vec4("ring_load_bad", 0, 0, 1, 4'b0110, MODE_RING, 4'b0010, 1'b0);
        vec4("ring_step_bad", 0, 1, 0, 4'd0, MODE_RING, 4'b0110, 1'b0);
        vec4("ring_recover", 0, 0, 0, 4'd0, MODE_RING, 4'b0001, 1'b0);

        vec4("load6", 0, 0, 1, 4'd6, MODE_UP, 4'b0001, 1'b0);
        vec4("hold6", 0, 0, 0, 4'd0, MODE_UP, 4'd6, 1'b0);
        vec4("async_rst", 1, 0, 0, 4'd0, MODE_UP, 4'd0, 1'b0);
        vec4("rst_over_load", 1, 1, 1, 4'd7, MODE_UP, 4'd0, 1'b0);
        vec4("rst_tc_down", 1, 1, 0, 4'd0, MODE_DOWN, 4'd0, 1'b1);
        vec4("rst_release", 0, 0, 0, 4'd0, MODE_UP, 4'd0, 1'b0);
        vec4("resume_en", 0, 1, 0, 4'd0, MODE_UP, 4'd0, 1'b0);
        vec4("resume_done", 0, 0, 0, 4'd0, MODE_UP, 4'd1, 1'b0);

        vec8("w8_reset", 1, 0, 0, 8'd0, 8'd0, 1'b0);
        vec8("w8_load254", 0, 0, 1, 8'd254, 8'd0, 1'b0);
        vec8("w8_254", 0, 1, 0, 8'd0, 8'd254, 1'b0);
        vec8("w8_255", 0, 1, 0, 8'd0, 8'd255, 1'b1);
        vec8("w8_wrap", 0, 1, 0, 8'd0, 8'd0, 1'b0);
        vec8("w8_one", 0, 0, 0, 8'd0, 8'd1, 1'b0);

        @(posedge clk);
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected entries never compared, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_param_mode_counter
